sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-port arbiter and timing sequencer for the board's 16-bit asynchronous SRAM.
- Shares the SRAM between a video pixel-fetch port (read-only, priority) and a host port (read/write, byte-enabled).
- Drives the SRAM_* pins directly and sits between the VGA fetch logic, the host bridge and the SRAM pads at top level.
- Bounded host starvation: the host is guaranteed a slot after MAX_WAIT lost arbitrations.

Parameters:
ADDR_W, 20, SRAM word address width.
ACCESS_CYCLES, 2, clock cycles per SRAM access; legal range is 2 or more.
MAX_WAIT, 4, consecutive lost arbitrations after which the host wins; legal range is 1 or more.

Ports:
clk_0  in  1  system clock
reset_n  in  1  synchronous, active-low reset
vid_req  in  1  video read request, level
vid_addr  in  ADDR_W  video word address
vid_gnt  out  1  one-cycle pulse: video request accepted
vid_rdata  out  16  video read data
vid_rvalid  out  1  one-cycle pulse: vid_rdata valid
host_req  in  1  host request, level
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host word address
host_wdata  in  16  host write data
host_be  in  2  byte enables {upper, lower}; write only
host_gnt  out  1  one-cycle pulse: host request accepted
host_rdata  out  16  host read data
host_rvalid  out  1  one-cycle pulse: host_rdata valid
busy  out  1  high when state is not IDLE
SRAM_ADDR  out  ADDR_W  SRAM address
SRAM_DQ  inout  16  SRAM data bus
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low

Behaviour:
- One clock (clk_0). Reset is synchronous and active-low (reset_n).
- Reset values, applied regardless of state, including mid-access:
  - State is IDLE; access counter and host_wait are 0.
  - All SRAM_* controls are 1; SRAM_ADDR is 0; SRAM_DQ is high-Z.
  - gnt and rvalid are 0; rdata is 0.
  - An aborted write leaves that SRAM word undefined.
- States: IDLE, ACCESS, TURN.
- Arbitration happens only in IDLE, sampled at the clock edge:
  - Host wins if host_req and (not vid_req or host_wait == MAX_WAIT).
  - Otherwise video wins if vid_req.
  - host_wait increments, saturating at MAX_WAIT, when host_req loses. It clears on a host grant.
- On a win:
  - Latch addr, we, wdata and be; go to ACCESS.
  - The winner's gnt is high during the first ACCESS cycle only.
  - Video requests are always reads.
- ACCESS lasts ACCESS_CYCLES cycles. SRAM_CE_N = 0 and SRAM_ADDR = latched address throughout.
  - Read: SRAM_OE_N = 0, SRAM_UB_N = SRAM_LB_N = 0, DQ high-Z. SRAM_DQ is captured at the edge ending the last ACCESS cycle. The winner's rvalid is high, with rdata, in the following cycle; rdata holds until the next read for that port.
  - Write: DQ driven with latched wdata for all ACCESS cycles. UB_N = ~be[1], LB_N = ~be[0]. SRAM_WE_N = 0 for cycles 0 to ACCESS_CYCLES-2 and 1 in the last cycle (data hold). OE_N = 1.
- Next state after ACCESS:
  - Read goes to IDLE.
  - Write goes to TURN.
- TURN lasts one cycle: all controls 1, DQ high-Z. Then IDLE.
- Latency: request sampled in IDLE at edge t gives gnt in cycle t+1 and rvalid in cycle t+ACCESS_CYCLES+1.
- Throughput:
  - Read: one access per ACCESS_CYCLES+1 cycles.
  - Write: one access per ACCESS_CYCLES+2 cycles.
- Requester rules:
  - Hold req and inputs stable until gnt. Dropping req before gnt withdraws the request.
  - Inputs may change after gnt.
  - To issue back-to-back requests, keep req high; it is re-arbitrated in the next IDLE cycle.
- host_be = 00 on a write: the full cycle is performed with UB_N = LB_N = 1, so memory is unchanged.
- vid_gnt and host_gnt are never high together; likewise vid_rvalid and host_rvalid.

Optional Feature:
SRAM_ARB_STATS_EN
- Defined: adds the following ports.
  - stat_clr  in  1: synchronous clear of the counters below; clear wins over a same-cycle increment.
  - vid_grants  out  32: saturating count of video grants.
  - host_grants  out  32: saturating count of host grants.
  - forced_grants  out  16: saturating count of host wins caused by host_wait == MAX_WAIT while vid_req was high.
  - All three counters reset to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset mid-write (ACCESS_CYCLES = 2), reset_n low for 3 cycles -> next cycle all controls = 1, DQ = Z, busy = 0, gnt and rvalid = 0; after release a host read is granted normally.
- Host write 0x00010 <- 0xBEEF (be = 11), then host read 0x00010 -> WE_N low exactly 1 cycle, TURN seen, host_rdata = 0xBEEF, host_rvalid exactly 3 cycles after the read's arbitration edge.
- Write 0x00020 <- 0x1234 (be = 11), then 0xAB00 (be = 10), then 0xFFFF (be = 00); read -> 0xAB34.
- vid_req and host_req both held high, MAX_WAIT = 4 -> grant sequence V,V,V,V,H repeating; no double grants.
- Host write immediately followed by a pending video read -> DQ Z for at least 1 cycle (TURN) before OE_N falls; vid_rvalid carries the SRAM model's data.
- SRAM_ARB_STATS_EN defined, 10 video and 2 host grants under contention (MAX_WAIT = 4) -> vid_grants = 10, host_grants = 2, forced_grants = 2; assert stat_clr for 1 cycle -> all counters 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Video/host arbiter and timing sequencer for a 16-bit async SRAM; gnt at t+1, rvalid at t+ACCESS_CYCLES+1; requesters hold req until gnt.
// Define SRAM_ARB_STATS_EN to add grant counters (vid_grants, host_grants, forced_grants) with stat_clr.
module sram_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int ACCESS_CYCLES = 2,
   parameter int MAX_WAIT      = 4
) (
   input  logic              clk_0,
   input  logic              reset_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic [15:0]       vid_rdata,
   output logic              vid_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [15:0]       host_wdata,
   input  logic [1:0]        host_be,
   output logic              host_gnt,
   output logic [15:0]       host_rdata,
   output logic              host_rvalid,
   output logic              busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [15:0]       SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
`ifdef SRAM_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [31:0]       vid_grants,
   output logic [31:0]       host_grants,
   output logic [15:0]       forced_grants
`endif
);

   localparam int CNT_W  = $clog2(ACCESS_CYCLES);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  LAST   = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_1  = CNT_W'(1);
   localparam logic [WAIT_W-1:0] WMAX   = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_1 = WAIT_W'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [WAIT_W-1:0] host_wait;
   logic              cur_host;
   logic              cur_we;
   logic              dq_oe;
   logic [15:0]       dq_out;
   logic              host_win;
   logic              vid_win;

   assign host_win = host_req && (!vid_req || host_wait == WMAX);
   assign vid_win  = vid_req && !host_win;
   assign busy     = (state != IDLE);
   assign SRAM_DQ  = dq_oe ? dq_out : 16'bz;

   always_ff @(posedge clk_0) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         host_wait   <= '0;
         cur_host    <= 1'b0;
         cur_we      <= 1'b0;
         dq_oe       <= 1'b0;
         dq_out      <= '0;
         vid_gnt     <= 1'b0;
         host_gnt    <= 1'b0;
         vid_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         vid_rdata   <= '0;
         host_rdata  <= '0;
         SRAM_ADDR   <= '0;
         SRAM_CE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_WE_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
      end else begin
         vid_gnt     <= 1'b0;
         host_gnt    <= 1'b0;
         vid_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (host_win || vid_win) begin
                  state     <= ACCESS;
                  cnt       <= '0;
                  cur_host  <= host_win;
                  cur_we    <= host_win && host_we;
                  host_gnt  <= host_win;
                  vid_gnt   <= vid_win;
                  SRAM_ADDR <= host_win ? host_addr : vid_addr;
                  SRAM_CE_N <= 1'b0;
                  if (host_win && host_we) begin
                     SRAM_OE_N <= 1'b1;
                     SRAM_WE_N <= 1'b0;
                     SRAM_UB_N <= ~host_be[1];
                     SRAM_LB_N <= ~host_be[0];
                     dq_oe     <= 1'b1;
                     dq_out    <= host_wdata;
                  end else begin
                     SRAM_OE_N <= 1'b0;
                     SRAM_WE_N <= 1'b1;
                     SRAM_UB_N <= 1'b0;
                     SRAM_LB_N <= 1'b0;
                  end
               end
               if (host_win)
                  host_wait <= '0;
               else if (host_req && host_wait != WMAX)
                  host_wait <= host_wait + WAIT_1;
            end
            ACCESS: begin
               if (cnt == LAST) begin
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_WE_N <= 1'b1;
                  SRAM_UB_N <= 1'b1;
                  SRAM_LB_N <= 1'b1;
                  dq_oe     <= 1'b0;
                  if (cur_we) begin
                     state <= TURN;
                  end else begin
                     state <= IDLE;
                     if (cur_host) begin
                        host_rdata  <= SRAM_DQ;
                        host_rvalid <= 1'b1;
                     end else begin
                        vid_rdata  <= SRAM_DQ;
                        vid_rvalid <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_1;
                  // WE_N rises for the final cycle so data is held past the write strobe
                  if (cnt + CNT_1 == LAST)
                     SRAM_WE_N <= 1'b1;
               end
            end
            TURN:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SRAM_ARB_STATS_EN
   logic vid_take;
   logic host_take;

   assign vid_take  = (state == IDLE) && vid_win;
   assign host_take = (state == IDLE) && host_win;

   always_ff @(posedge clk_0) begin
      if (!reset_n || stat_clr) begin
         vid_grants    <= '0;
         host_grants   <= '0;
         forced_grants <= '0;
      end else begin
         if (vid_take && vid_grants != 32'hFFFF_FFFF)
            vid_grants <= vid_grants + 32'd1;
         if (host_take && host_grants != 32'hFFFF_FFFF)
            host_grants <= host_grants + 32'd1;
         // a host win while video is requesting can only come from the starvation limit
         if (host_take && vid_req && forced_grants != 16'hFFFF)
            forced_grants <= forced_grants + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, shadow memory, read-data and grant-order scoreboards.
module tb_sram_arbiter;
   localparam int ADDR_W = 20;
   localparam int AC     = 2;
   localparam int MW     = 4;

   logic              clk_0 = 1'b0;
   logic              reset_n = 1'b0;
   logic              vid_req = 1'b0;
   logic [ADDR_W-1:0] vid_addr = '0;
   logic              vid_gnt;
   logic [15:0]       vid_rdata;
   logic              vid_rvalid;
   logic              host_req = 1'b0;
   logic              host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [15:0]       host_wdata = '0;
   logic [1:0]        host_be = '0;
   logic              host_gnt;
   logic [15:0]       host_rdata;
   logic              host_rvalid;
   logic              busy;
   logic [ADDR_W-1:0] sram_addr;
   wire  [15:0]       sram_dq;
   logic              ce_n, oe_n, we_n, ub_n, lb_n;
`ifdef SRAM_ARB_STATS_EN
   logic              stat_clr = 1'b0;
   logic [31:0]       vid_grants, host_grants;
   logic [15:0]       forced_grants;
`endif

   sram_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC), .MAX_WAIT(MW)) dut (
      .clk_0(clk_0), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_be(host_be), .host_gnt(host_gnt),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid), .busy(busy),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n),
      .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
`ifdef SRAM_ARB_STATS_EN
      , .stat_clr(stat_clr), .vid_grants(vid_grants),
      .host_grants(host_grants), .forced_grants(forced_grants)
`endif
   );

   always #5 clk_0 = ~clk_0;

   // behavioural SRAM: drives the bus on reads, stores enabled bytes while WE_N is low
   logic [15:0] mem    [0:255];
   logic [15:0] shadow [0:255];
   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'bz;
   always @(posedge clk_0) begin
      if (!ce_n && !we_n) begin
         if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
         if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      end
   end

   int total = 0;
   int bad   = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   logic [15:0] hq[$];
   logic [15:0] vq[$];
   byte         gnt_q[$];
   logic        track_order = 1'b0;
   logic        mon_en = 1'b0;
   int          cyc = 0;
   int          hg_cyc = 0;
   int          we_run = 0;
   int          turn_cnt = 0;
   logic        wp = 1'b0;
   logic        prev_oe = 1'b1;

   always @(posedge clk_0) cyc <= cyc + 1;

   always @(negedge clk_0) begin
      if (!mon_en) begin
         we_run  <= 0;
         wp      <= 1'b0;
         prev_oe <= 1'b1;
      end else begin
         if (vid_gnt || host_gnt) begin
            check("gnt_excl", {31'd0, vid_gnt & host_gnt}, 32'd0);
            if (track_order) begin
               check("order_left", (gnt_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
               if (gnt_q.size() > 0)
                  check("order", host_gnt ? 32'h48 : 32'h56, {24'd0, gnt_q.pop_front()});
            end
         end
         if (host_gnt) hg_cyc <= cyc;
         if (vid_rvalid || host_rvalid)
            check("rv_excl", {31'd0, vid_rvalid & host_rvalid}, 32'd0);
         if (host_rvalid) begin
            check("h_lat", cyc - hg_cyc, AC);
            check("h_sb", (hq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (hq.size() > 0) check("h_data", {16'd0, host_rdata}, {16'd0, hq.pop_front()});
         end
         if (vid_rvalid) begin
            check("v_sb", (vq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (vq.size() > 0) check("v_data", {16'd0, vid_rdata}, {16'd0, vq.pop_front()});
         end
         if (!we_n) begin
            we_run <= we_run + 1;
            wp     <= 1'b1;
         end else if (we_run != 0) begin
            check("we_len", we_run, AC - 1);
            we_run <= 0;
         end
         if (busy && ce_n) begin
            turn_cnt <= turn_cnt + 1;
            wp       <= 1'b0;
         end
         if (!oe_n && prev_oe)
            check("turn_b4_oe", {31'd0, wp}, 32'd0);
         prev_oe <= oe_n;
      end
   end

   task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [15:0] d, input logic [1:0] be);
      int n;
      host_we = we; host_addr = a; host_wdata = d; host_be = be; host_req = 1'b1;
      if (we) begin
         if (be[1]) shadow[a[7:0]][15:8] = d[15:8];
         if (be[0]) shadow[a[7:0]][7:0]  = d[7:0];
      end else begin
         hq.push_back(shadow[a[7:0]]);
      end
      n = 0;
      do begin @(negedge clk_0); n++; end while (!host_gnt && n < 200);
      check("h_gnt", {31'd0, host_gnt}, 32'd1);
      host_req = 1'b0;
   endtask

   task automatic vid_op(input logic [ADDR_W-1:0] a);
      int n;
      vid_addr = a; vid_req = 1'b1;
      vq.push_back(shadow[a[7:0]]);
      n = 0;
      do begin @(negedge clk_0); n++; end while (!vid_gnt && n < 200);
      check("v_gnt", {31'd0, vid_gnt}, 32'd1);
      vid_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin @(negedge clk_0); #1; n++; end
         while ((hq.size() != 0 || vq.size() != 0 || busy) && n < 200);
      check("drain", hq.size() + vq.size(), 0);
   endtask

   task automatic check_rst();
      check("rst_ctl", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
      check("rst_addr", {12'd0, sram_addr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_gnt", {30'd0, vid_gnt, host_gnt}, 32'd0);
      check("rst_rv", {30'd0, vid_rvalid, host_rvalid}, 32'd0);
      check("rst_hrd", {16'd0, host_rdata}, 32'd0);
      check("rst_vrd", {16'd0, vid_rdata}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = {8'hA5, 8'(i)};
         shadow[i] = {8'hA5, 8'(i)};
      end
      repeat (3) @(negedge clk_0);
      check_rst();
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // read to load host_rdata, then reset in the middle of a write
      host_op(1'b0, 20'h00041, 16'h0, 2'b00);
      drain();
      host_op(1'b1, 20'h00050, 16'hDEAD, 2'b11);
      mon_en  = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk_0);
      check_rst();
      reset_n = 1'b1;
      mon_en  = 1'b1;
      host_op(1'b0, 20'h00040, 16'h0, 2'b00);
      drain();

      // write then read back, one TURN cycle per write
      t0 = turn_cnt;
      host_op(1'b1, 20'h00010, 16'hBEEF, 2'b11);
      host_op(1'b0, 20'h00010, 16'h0, 2'b00);
      drain();
      check("turn_wr1", turn_cnt - t0, 1);

      // byte enables, including an all-disabled write
      t0 = turn_cnt;
      host_op(1'b1, 20'h00020, 16'h1234, 2'b11);
      host_op(1'b1, 20'h00020, 16'hAB00, 2'b10);
      host_op(1'b1, 20'h00020, 16'hFFFF, 2'b00);
      host_op(1'b0, 20'h00020, 16'h0, 2'b00);
      drain();
      check("turn_wr3", turn_cnt - t0, 3);
      check("be_mem", {16'd0, mem[8'h20]}, 32'h0000AB34);

      // contention: MAX_WAIT video grants then one forced host grant
`ifdef SRAM_ARB_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk_0);
      stat_clr = 1'b0;
`endif
      for (int i = 0; i < 12; i++) gnt_q.push_back((i == 4 || i == 9) ? 8'h48 : 8'h56);
      track_order = 1'b1;
      fork
         for (int i = 0; i < 10; i++) vid_op(20'h00060 + 20'(i));
         for (int i = 0; i < 2; i++) host_op(1'b0, 20'h00080 + 20'(i), 16'h0, 2'b00);
      join
      drain();
      track_order = 1'b0;
      check("order_done", gnt_q.size(), 0);
`ifdef SRAM_ARB_STATS_EN
      check("st_vid", vid_grants, 32'd10);
      check("st_host", host_grants, 32'd2);
      check("st_forced", {16'd0, forced_grants}, 32'd2);
      stat_clr = 1'b1;
      @(negedge clk_0);
      stat_clr = 1'b0;
      check("st_clr", vid_grants | host_grants | {16'd0, forced_grants}, 32'd0);
`endif

      // write followed by a pending video read of the same word
      t0 = turn_cnt;
      host_op(1'b1, 20'h00030, 16'h7777, 2'b11);
      vid_op(20'h00030);
      drain();
      check("turn_wv", turn_cnt - t0, 1);

      repeat (2) @(negedge clk_0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
